// File: rtl/arm_pkg.sv
// Shared ARM pipeline constants and the fetch-queue entry type.
package arm_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned FQ_DEPTH = 4;

   localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instruction;
   } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Fetch-queue entry array: one synchronous write port, one asynchronous read port.
module fq_storage #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   // Contents are deliberately left unreset; the queue masks reads while empty.
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// IF->ID prefetch queue of {PC, instruction} pairs; in_ready doubles as IF's ~freeze.
module if_fetch_queue
   import arm_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_W,
   parameter int unsigned DEPTH = FQ_DEPTH,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_pc,
   input  logic [WIDTH-1:0] in_instruction,
   output logic             in_ready,
   input  logic             flush,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0] out_instruction,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count_q;
   logic               empty, full, push, pop;
   logic [2*WIDTH-1:0] rdata;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   fq_storage #(
      .DATA_W (2 * WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (AW)
   ) u_storage (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr[AW-1:0]),
      .wdata ({in_pc, in_instruction}),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rdata)
   );

   // Empty queue presents a NOP bubble rather than stale storage.
   assign out_pc          = empty ? '0 : rdata[2*WIDTH-1:WIDTH];
   assign out_instruction = empty ? '0 : rdata[WIDTH-1:0];
   assign count           = count_q;

endmodule
